// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg -- shared definitions for the MIPS inter-stage pipeline register.
//   RESET_PC_DEF   PC loaded on Reset/Flush
//   NOP_INS        instruction word of an inserted bubble
//   TNEW_*_DEF     default position/width of the Tnew field inside the control word
//   CTRL_* bits    RegWrite/MemWrite positions (all-zero ctrl never writes)
//   stage_op_e     resolved per-edge action after applying input priority
//   satdec()       saturating decrement used to age Tnew
package pipe_stage_reg_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INS      = 32'h0000_0000;
  localparam int          TNEW_LSB_DEF = 8;
  localparam int          TNEW_W_DEF   = 3;
  localparam int          SATDEC_W     = 8;  // widest Tnew field the helper handles

  typedef enum logic [2:0] {
    OP_RESET,
    OP_FLUSH,
    OP_HOLD,
    OP_BUBBLE,
    OP_LOAD
  } stage_op_e;

  // Tnew counts down to 0 and sticks there; it must never wrap to the max value.
  function automatic logic [SATDEC_W-1:0] satdec(input logic [SATDEC_W-1:0] x);
    return (x == '0) ? '0 : x - SATDEC_W'(1);
  endfunction

  // Reset > Flush > Hold > Bubble > load.
  function automatic stage_op_e decode_op(input logic reset, input logic flush,
                                          input logic hold, input logic bubble);
    if (reset)       return OP_RESET;
    else if (flush)  return OP_FLUSH;
    else if (hold)   return OP_HOLD;
    else if (bubble) return OP_BUBBLE;
    else             return OP_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if -- bundle of stage-register controls, upstream payload and
// registered payload.
//   master: upstream/hazard unit (drives Flush/Hold/Bubble and *In, reads *Out)
//   slave : the pipeline register itself
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2,
  parameter int CTRL_W = 31
);
  logic                     Flush;
  logic                     Hold;
  logic                     Bubble;
  logic                     ValidIn;
  logic [31:0]              InsIn;
  logic [31:0]              PCIn;
  logic                     BDIn;
  logic [NUM_RD*DATA_W-1:0] RdIn;
  logic [CTRL_W-1:0]        CtrlIn;

  logic                     ValidOut;
  logic [31:0]              InsOut;
  logic [31:0]              PCOut;
  logic                     BDOut;
  logic [NUM_RD*DATA_W-1:0] RdOut;
  logic [CTRL_W-1:0]        CtrlOut;
  logic [31:0]              BubbleCnt;
  logic [31:0]              HoldCnt;

  modport master (
    output Flush, Hold, Bubble, ValidIn, InsIn, PCIn, BDIn, RdIn, CtrlIn,
    input  ValidOut, InsOut, PCOut, BDOut, RdOut, CtrlOut, BubbleCnt, HoldCnt
  );

  modport slave (
    input  Flush, Hold, Bubble, ValidIn, InsIn, PCIn, BDIn, RdIn, CtrlIn,
    output ValidOut, InsOut, PCOut, BDOut, RdOut, CtrlOut, BubbleCnt, HoldCnt
  );
endinterface

// File: rtl/pipe_stage_reg_perf_cnt.sv
// pipe_stage_reg_perf_cnt -- pair of free-running 32-bit event counters.
//   Clk, Reset          clock, synchronous active-high clear
//   inc_bubble/inc_hold one-cycle increment strobes
//   bubble_cnt/hold_cnt counts since Reset, wrap at 2^32
module pipe_stage_reg_perf_cnt (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        inc_bubble,
  input  logic        inc_hold,
  output logic [31:0] bubble_cnt,
  output logic [31:0] hold_cnt
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      if (inc_bubble) bubble_cnt <= bubble_cnt + 32'd1;
      if (inc_hold)   hold_cnt   <= hold_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- parametrised inter-stage register (D/E, E/M, M/W) for the
// 5-stage MIPS core.
//   Clk    rising-edge clock
//   Reset  synchronous, active-high
//   stage  pipe_stage_reg_if.slave: Flush/Hold/Bubble, upstream payload
//          (ValidIn, InsIn, PCIn, BDIn, RdIn, CtrlIn), registered payload
//          (ValidOut, InsOut, PCOut, BDOut, RdOut, CtrlOut), BubbleCnt/HoldCnt.
// Bubble inserts a NOP but keeps PC/BD so a later exception still reports the
// right EPC. Hold freezes the slot yet still ages Tnew, since the producer keeps
// progressing in real time while we wait.
// Optional feature: define PIPE_STAT_EN to build the bubble/hold counters;
// otherwise BubbleCnt/HoldCnt are tied to 0.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          NUM_RD   = 2,
  parameter int          CTRL_W   = 31,
  parameter int          TNEW_LSB = TNEW_LSB_DEF,
  parameter int          TNEW_W   = TNEW_W_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic           Clk,
  input  logic           Reset,
  pipe_stage_reg_if.slave stage
);

  stage_op_e op;
  assign op = decode_op(Reset, stage.Flush, stage.Hold, stage.Bubble);

  logic                     valid_q;
  logic [31:0]              ins_q;
  logic [31:0]              pc_q;
  logic                     bd_q;
  logic [NUM_RD*DATA_W-1:0] rd_q;
  logic [CTRL_W-1:0]        ctrl_q;

  // Stored Tnew is one cycle "behind": the output always shows it aged by one,
  // and a held cycle commits that aging into the register.
  logic [TNEW_W-1:0] tnew_q;
  logic [TNEW_W-1:0] tnew_dec;
  assign tnew_q   = ctrl_q[TNEW_LSB +: TNEW_W];
  assign tnew_dec = TNEW_W'(satdec(SATDEC_W'(tnew_q)));

  always_ff @(posedge Clk) begin
    case (op)
      OP_RESET, OP_FLUSH: begin
        valid_q <= 1'b0;
        ins_q   <= NOP_INS;
        pc_q    <= RESET_PC;
        bd_q    <= 1'b0;
        rd_q    <= '0;
        ctrl_q  <= '0;
      end
      OP_HOLD: begin
        ctrl_q[TNEW_LSB +: TNEW_W] <= tnew_dec;
      end
      OP_BUBBLE: begin
        valid_q <= 1'b0;
        ins_q   <= NOP_INS;
        pc_q    <= stage.PCIn;
        bd_q    <= stage.BDIn;
        rd_q    <= '0;
        ctrl_q  <= '0;
      end
      default: begin
        valid_q <= stage.ValidIn;
        ins_q   <= stage.InsIn;
        pc_q    <= stage.PCIn;
        bd_q    <= stage.BDIn;
        rd_q    <= stage.RdIn;
        ctrl_q  <= stage.CtrlIn;
      end
    endcase
  end

  logic [CTRL_W-1:0] ctrl_out;
  always_comb begin
    ctrl_out                     = ctrl_q;
    ctrl_out[TNEW_LSB +: TNEW_W] = tnew_dec;
  end

  assign stage.ValidOut = valid_q;
  assign stage.InsOut   = ins_q;
  assign stage.PCOut    = pc_q;
  assign stage.BDOut    = bd_q;
  assign stage.RdOut    = rd_q;
  assign stage.CtrlOut  = ctrl_out;

`ifdef PIPE_STAT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] hold_cnt;

  pipe_stage_reg_perf_cnt u_perf_cnt (
    .Clk        (Clk),
    .Reset      (Reset),
    .inc_bubble (op == OP_BUBBLE),
    .inc_hold   (op == OP_HOLD),
    .bubble_cnt (bubble_cnt),
    .hold_cnt   (hold_cnt)
  );

  assign stage.BubbleCnt = bubble_cnt;
  assign stage.HoldCnt   = hold_cnt;
`else
  assign stage.BubbleCnt = 32'd0;
  assign stage.HoldCnt   = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- scoreboard bench for pipe_stage_reg (NUM_RD=3).
// The driver applies one action per cycle and pushes the expected registered
// view; an independent monitor pops one entry after each rising edge.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int NUM_RD = 3;
  localparam int CTRL_W = 31;
  localparam int RD_W   = NUM_RD * DATA_W;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .NUM_RD(NUM_RD), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .NUM_RD (NUM_RD),
    .CTRL_W (CTRL_W)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .stage (bus)
  );

  typedef struct {
    logic            valid;
    logic [31:0]     ins;
    logic [31:0]     pc;
    logic            bd;
    logic [RD_W-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]     bcnt;
    logic [31:0]     hcnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state of the stage, updated with the rules written as arithmetic.
  logic            m_valid, m_bd;
  logic [31:0]     m_ins, m_pc;
  logic [RD_W-1:0] m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int unsigned     m_bubbles, m_holds;

  function automatic int unsigned tnew_of(input logic [CTRL_W-1:0] c);
    return (int'(c) >> 8) & 7;
  endfunction

  // Visible ctrl: stored word with its Tnew field reduced by one unless already 0.
  function automatic logic [CTRL_W-1:0] shown_ctrl(input logic [CTRL_W-1:0] c);
    if (tnew_of(c) > 0) return c - CTRL_W'(256);
    return c;
  endfunction

  task automatic step(input logic rst, input logic fl, input logic hd, input logic bb,
                      input logic vin, input logic [31:0] ins, input logic [31:0] pc,
                      input logic bdin, input logic [RD_W-1:0] rd,
                      input logic [CTRL_W-1:0] ctrl);
    exp_t e;
    @(negedge Clk);
    Reset       = rst;
    bus.Flush   = fl;
    bus.Hold    = hd;
    bus.Bubble  = bb;
    bus.ValidIn = vin;
    bus.InsIn   = ins;
    bus.PCIn    = pc;
    bus.BDIn    = bdin;
    bus.RdIn    = rd;
    bus.CtrlIn  = ctrl;
    if (rst || fl) begin
      m_valid = 0; m_ins = 0; m_pc = 32'h3000; m_bd = 0; m_rd = 0; m_ctrl = 0;
      if (rst) begin m_bubbles = 0; m_holds = 0; end
    end else if (hd) begin
      m_ctrl = shown_ctrl(m_ctrl);
      m_holds++;
    end else if (bb) begin
      m_valid = 0; m_ins = 0; m_rd = 0; m_ctrl = 0; m_pc = pc; m_bd = bdin;
      m_bubbles++;
    end else begin
      m_valid = vin; m_ins = ins; m_pc = pc; m_bd = bdin; m_rd = rd; m_ctrl = ctrl;
    end
    e.valid = m_valid; e.ins = m_ins; e.pc = m_pc; e.bd = m_bd; e.rd = m_rd;
    e.ctrl  = shown_ctrl(m_ctrl);
`ifdef PIPE_STAT_EN
    e.bcnt = m_bubbles; e.hcnt = m_holds;
`else
    e.bcnt = 0; e.hcnt = 0;
`endif
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [RD_W-1:0] act, input logic [RD_W-1:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, vectors, act, req);
    end
  endtask

  // Monitor: one registered view per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        chk("valid", RD_W'(bus.ValidOut), RD_W'(e.valid));
        chk("ins",   RD_W'(bus.InsOut),   RD_W'(e.ins));
        chk("pc",    RD_W'(bus.PCOut),    RD_W'(e.pc));
        chk("bd",    RD_W'(bus.BDOut),    RD_W'(e.bd));
        chk("rd",    bus.RdOut,           e.rd);
        chk("ctrl",  RD_W'(bus.CtrlOut),  RD_W'(e.ctrl));
        chk("bcnt",  RD_W'(bus.BubbleCnt), RD_W'(e.bcnt));
        chk("hcnt",  RD_W'(bus.HoldCnt),  RD_W'(e.hcnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout vec=%0d got=running want=finished", vectors);
    $fatal(1, "timeout");
  end

  function automatic logic [RD_W-1:0] rnd_rd();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] c;
    int unsigned       r;
    int                wait_cyc;
    Reset = 1; bus.Flush = 0; bus.Hold = 0; bus.Bubble = 0; bus.ValidIn = 0;
    bus.InsIn = 0; bus.PCIn = 0; bus.BDIn = 0; bus.RdIn = 0; bus.CtrlIn = 0;
    m_valid = 0; m_ins = 0; m_pc = 0; m_bd = 0; m_rd = 0; m_ctrl = 0;
    m_bubbles = 0; m_holds = 0;

    // Reset, then load Tnew=3 and hold three cycles (Tnew shows 2,1,0,0).
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rd = rnd_rd();
    step(0, 0, 0, 0, 1, 32'h0000_0021, 32'h3004, 0, rd, CTRL_W'(32'h0000_0305));
    step(0, 0, 1, 0, 1, 32'hFFFF_FFFF, 32'h9999, 1, rnd_rd(), CTRL_W'($urandom));
    step(0, 0, 1, 0, 1, 32'hFFFF_FFFF, 32'h9999, 1, rnd_rd(), CTRL_W'($urandom));
    step(0, 0, 1, 0, 1, 32'hFFFF_FFFF, 32'h9999, 1, rnd_rd(), CTRL_W'($urandom));
    // Bubble keeps PC/BD for EPC.
    step(0, 0, 0, 1, 1, 32'h1234_5678, 32'h3010, 1, rnd_rd(), CTRL_W'($urandom));
    // Hold beats Bubble; Flush beats both.
    step(0, 0, 0, 0, 1, 32'h0000_0042, 32'h3020, 0, rnd_rd(), CTRL_W'(32'h0000_0700));
    step(0, 0, 1, 1, 1, 32'h0000_0043, 32'h3024, 1, rnd_rd(), CTRL_W'($urandom));
    step(0, 1, 1, 1, 1, 32'h0000_0044, 32'h3028, 1, rnd_rd(), CTRL_W'($urandom));
    // Operand channel 2 lands in the top slice.
    rd = {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1111_2222};
    step(0, 0, 0, 0, 1, 32'h0000_0021, 32'h3030, 0, rd, CTRL_W'(32'h0000_0001));
    // Reset in the middle of a hold drops the held slot.
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 32'h5, 32'h5, 1, rnd_rd(), CTRL_W'($urandom));

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      c = CTRL_W'($urandom);
      step(r < 2, (r >= 2 && r < 7), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           1'($urandom), $urandom, $urandom, 1'($urandom), rnd_rd(), c);
    end

    step(0, 0, 0, 0, 0, 0, 32'h4000, 0, 0, 0);
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge Clk);
      wait_cyc++;
    end
    #2;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain got=%0d want=0 pending", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
